sparse_pe_scheduler: RTL and testbench

Sequences the sparse-convolution PE datapath. It takes compressed, packed feature and weight lists (value, row and column per nonzero, plus valid counts). It walks the cartesian product of nonzero features and nonzero weights, and issues one (feature, weight, output-coordinate) tuple per cycle to the multiplier/accumulator over a valid/ready handshake. It signals completion with a done pulse and sits between the compressed-operand buffers and the PE multiply array.

---
 rtl/sparse_pe_pkg.sv | 31 +++
 rtl/sparse_pe_scheduler_lane_select.sv | 23 ++
 rtl/sparse_pe_scheduler.sv | 169 ++++++++++++++++
 tb/tb_sparse_pe_scheduler.sv | 271 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/sparse_pe_pkg.sv
// Shared types and constants for the sparse-convolution PE scheduler.
// Holds the FSM encoding, default geometry and the count clamp helper.
package sparse_pe_pkg;

  localparam int WORD_LENGTH        = 8;
  localparam int COL_LENGTH         = 8;
  localparam int DOUBLE_WORD_LENGTH = 16;
  localparam int KERNEL_SIZE        = 5;
  localparam int IMAGE_SIZE         = 7;
  localparam int MAX_FEATURE        = 52;
  localparam int MAX_WEIGHT         = 28;

  localparam int FEAT_IDX_W = $clog2(MAX_FEATURE);
  localparam int WGT_IDX_W  = $clog2(MAX_WEIGHT);
  localparam int OUT_GRID   = IMAGE_SIZE + KERNEL_SIZE - 1;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_RUN    = 2'd1,
    ST_FINISH = 2'd2
  } state_e;

  // Limit a requested entry count to the list capacity.
  function automatic logic [DOUBLE_WORD_LENGTH-1:0] clamp_count(
    input logic [DOUBLE_WORD_LENGTH-1:0] num,
    input logic [DOUBLE_WORD_LENGTH-1:0] cap
  );
    return (num > cap) ? cap : num;
  endfunction

endpackage

// File: rtl/sparse_pe_scheduler_lane_select.sv
// Entry selector: picks entry idx out of a packed list; out-of-range reads 0.
// Built as a constant-slice mux so no variable part-select is needed.
module sparse_lane_select
  import sparse_pe_pkg::*;
#(
  parameter int n_entries = MAX_FEATURE,
  parameter int width     = WORD_LENGTH,
  parameter int idx_w     = FEAT_IDX_W
) (
  input  logic [n_entries*width-1:0] vec,
  input  logic [idx_w-1:0]           idx,
  output logic [width-1:0]           data
);

  // Mux the selected entry onto data.
  always_comb begin
    data = '0;
    for (int i = 0; i < n_entries; i++) begin
      data = (idx == idx_w'(i)) ? vec[i*width +: width] : data;
    end
  end

endmodule

// File: rtl/sparse_pe_scheduler.sv
// Walks the feature x weight nonzero product (weight outer, feature inner)
// and issues one registered tuple per transfer to the PE multiply array.
module sparse_pe_scheduler
  import sparse_pe_pkg::*;
#(
  parameter int word_length        = WORD_LENGTH,
  parameter int col_length         = COL_LENGTH,
  parameter int double_word_length = DOUBLE_WORD_LENGTH,
  parameter int max_feature        = MAX_FEATURE,
  parameter int max_weight         = MAX_WEIGHT
) (
  input  logic                              clk,
  input  logic                              rst,
  input  logic                              start,
  input  logic                              clear,
  input  logic [double_word_length-1:0]     feature_valid_num,
  input  logic [double_word_length-1:0]     weight_valid_num,
  input  logic [max_feature*word_length-1:0] feature_value,
  input  logic [max_feature*col_length-1:0]  feature_cols,
  input  logic [max_feature*col_length-1:0]  feature_rows,
  input  logic [max_weight*word_length-1:0]  weight_value,
  input  logic [max_weight*col_length-1:0]   weight_cols,
  input  logic [max_weight*col_length-1:0]   weight_rows,
  output logic                              mul_valid,
  input  logic                              mul_ready,
  output logic [word_length-1:0]            mul_feature,
  output logic [word_length-1:0]            mul_weight,
  output logic [col_length-1:0]             mul_row,
  output logic [col_length-1:0]             mul_col,
  output logic                              mul_last,
  output logic                              busy,
  output logic                              done,
  output logic [double_word_length-1:0]     pair_count
);

  localparam int fidx_w = $clog2(max_feature);
  localparam int widx_w = $clog2(max_weight);
  localparam logic [double_word_length-1:0] one_dw = {{(double_word_length-1){1'b0}}, 1'b1};

  state_e                        state_r;
  logic [fidx_w-1:0]             fi_r;
  logic [fidx_w-1:0]             fi_nxt_s;
  logic [widx_w-1:0]             wi_r;
  logic [widx_w-1:0]             wi_nxt_s;
  logic [double_word_length-1:0] cnt_f_r;
  logic [double_word_length-1:0] cnt_w_r;
  logic [double_word_length-1:0] f_clamp_s;
  logic [double_word_length-1:0] w_clamp_s;
  logic [double_word_length-1:0] fi_ext_s;
  logic [double_word_length-1:0] wi_ext_s;
  logic                          f_end_s;
  logic                          last_s;
  logic                          xfer_s;
  logic [word_length-1:0]        f_val_s;
  logic [word_length-1:0]        w_val_s;
  logic [col_length-1:0]         f_row_s;
  logic [col_length-1:0]         f_col_s;
  logic [col_length-1:0]         w_row_s;
  logic [col_length-1:0]         w_col_s;

  sparse_lane_select #(.n_entries(max_feature), .width(word_length), .idx_w(fidx_w))
    u_sel_f_val (.vec(feature_value), .idx(fi_r), .data(f_val_s));
  sparse_lane_select #(.n_entries(max_feature), .width(col_length), .idx_w(fidx_w))
    u_sel_f_row (.vec(feature_rows), .idx(fi_r), .data(f_row_s));
  sparse_lane_select #(.n_entries(max_feature), .width(col_length), .idx_w(fidx_w))
    u_sel_f_col (.vec(feature_cols), .idx(fi_r), .data(f_col_s));
  sparse_lane_select #(.n_entries(max_weight), .width(word_length), .idx_w(widx_w))
    u_sel_w_val (.vec(weight_value), .idx(wi_r), .data(w_val_s));
  sparse_lane_select #(.n_entries(max_weight), .width(col_length), .idx_w(widx_w))
    u_sel_w_row (.vec(weight_rows), .idx(wi_r), .data(w_row_s));
  sparse_lane_select #(.n_entries(max_weight), .width(col_length), .idx_w(widx_w))
    u_sel_w_col (.vec(weight_cols), .idx(wi_r), .data(w_col_s));

  assign f_clamp_s = clamp_count(feature_valid_num, double_word_length'(max_feature));
  assign w_clamp_s = clamp_count(weight_valid_num, double_word_length'(max_weight));
  assign fi_ext_s  = double_word_length'(fi_r);
  assign wi_ext_s  = double_word_length'(wi_r);
  assign f_end_s   = (fi_ext_s == (cnt_f_r - one_dw));
  assign last_s    = f_end_s && (wi_ext_s == (cnt_w_r - one_dw));
  assign xfer_s    = mul_valid & mul_ready;

  // fi_r/wi_r always point at the next tuple to load; advance them in walk order.
  always_comb begin
    fi_nxt_s = fi_r;
    wi_nxt_s = wi_r;
    if (f_end_s) begin
      fi_nxt_s = '0;
      wi_nxt_s = wi_r + {{(widx_w-1){1'b0}}, 1'b1};
    end else begin
      fi_nxt_s = fi_r + {{(fidx_w-1){1'b0}}, 1'b1};
    end
  end

  // Control FSM with registered tuple, handshake and status outputs.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_r     <= ST_IDLE;
      fi_r        <= '0;
      wi_r        <= '0;
      cnt_f_r     <= '0;
      cnt_w_r     <= '0;
      mul_valid   <= 1'b0;
      mul_feature <= '0;
      mul_weight  <= '0;
      mul_row     <= '0;
      mul_col     <= '0;
      mul_last    <= 1'b0;
      busy        <= 1'b0;
      done        <= 1'b0;
      pair_count  <= '0;
    end else if (clear) begin
      state_r   <= ST_IDLE;
      mul_valid <= 1'b0;
      mul_last  <= 1'b0;
      busy      <= 1'b0;
      done      <= 1'b0;
    end else begin
      done <= 1'b0;
      case (state_r)
        ST_IDLE: begin
          if (start) begin
            cnt_f_r    <= f_clamp_s;
            cnt_w_r    <= w_clamp_s;
            fi_r       <= '0;
            wi_r       <= '0;
            pair_count <= '0;
            busy       <= 1'b1;
            if ((f_clamp_s == '0) || (w_clamp_s == '0)) begin
              state_r <= ST_FINISH;
            end else begin
              state_r <= ST_RUN;
            end
          end
        end
        ST_RUN: begin
          if (xfer_s) begin
            pair_count <= pair_count + one_dw;
          end
          if (xfer_s && mul_last) begin
            mul_valid <= 1'b0;
            mul_last  <= 1'b0;
            state_r   <= ST_FINISH;
          end else if (!mul_valid || mul_ready) begin
            // First load after entry, or refill on transfer; stalls hold everything.
            mul_valid   <= 1'b1;
            mul_feature <= f_val_s;
            mul_weight  <= w_val_s;
            mul_row     <= f_row_s + w_row_s;
            mul_col     <= f_col_s + w_col_s;
            mul_last    <= last_s;
            fi_r        <= fi_nxt_s;
            wi_r        <= wi_nxt_s;
          end
        end
        ST_FINISH: begin
          done    <= 1'b1;
          busy    <= 1'b0;
          state_r <= ST_IDLE;
        end
        default: begin
          state_r   <= ST_IDLE;
          mul_valid <= 1'b0;
          busy      <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_sparse_pe_scheduler.sv
// Table-driven bench for sparse_pe_scheduler with a tuple scoreboard,
// plus hand sequences for clear-on-last and asynchronous reset mid-job.
module tb_sparse_pe_scheduler;

  localparam int WL = 8;
  localparam int CL = 8;
  localparam int DW = 16;
  localparam int MF = 52;
  localparam int MW = 28;

  logic             clk = 1'b0;
  logic             rst;
  logic             start;
  logic             clear;
  logic [DW-1:0]    feature_valid_num;
  logic [DW-1:0]    weight_valid_num;
  logic [MF*WL-1:0] feature_value;
  logic [MF*CL-1:0] feature_cols;
  logic [MF*CL-1:0] feature_rows;
  logic [MW*WL-1:0] weight_value;
  logic [MW*CL-1:0] weight_cols;
  logic [MW*CL-1:0] weight_rows;
  logic             mul_valid;
  logic             mul_ready;
  logic [WL-1:0]    mul_feature;
  logic [WL-1:0]    mul_weight;
  logic [CL-1:0]    mul_row;
  logic [CL-1:0]    mul_col;
  logic             mul_last;
  logic             busy;
  logic             done;
  logic [DW-1:0]    pair_count;

  sparse_pe_scheduler dut (
    .clk(clk), .rst(rst), .start(start), .clear(clear),
    .feature_valid_num(feature_valid_num), .weight_valid_num(weight_valid_num),
    .feature_value(feature_value), .feature_cols(feature_cols), .feature_rows(feature_rows),
    .weight_value(weight_value), .weight_cols(weight_cols), .weight_rows(weight_rows),
    .mul_valid(mul_valid), .mul_ready(mul_ready),
    .mul_feature(mul_feature), .mul_weight(mul_weight),
    .mul_row(mul_row), .mul_col(mul_col), .mul_last(mul_last),
    .busy(busy), .done(done), .pair_count(pair_count)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic [7:0] f;
    logic [7:0] w;
    logic [7:0] row;
    logic [7:0] col;
    logic       last;
  } tup_t;

  typedef struct {
    int fnum;
    int wnum;
    int stall_k;
    int stall_len;
    int start_k;
    int exp_pairs;
  } vec_t;

  logic [7:0] fv[MF];
  logic [7:0] fr[MF];
  logic [7:0] fc[MF];
  logic [7:0] wv[MW];
  logic [7:0] wr[MW];
  logic [7:0] wc[MW];

  tup_t exp_q[$];
  tup_t seen_q[$];
  vec_t tbl[8];
  int   tests_run = 0;
  int   tests_failed = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests_run++;
    if (act !== exp) begin
      tests_failed++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic run_job(input vec_t v, input string tag);
    int   nf, nw, k, stalled, last_neg, budget, cyc;
    bit   got_done, first_seen, holding, pulsed;
    tup_t e, cur, held;
    nf = (v.fnum > MF) ? MF : v.fnum;
    nw = (v.wnum > MW) ? MW : v.wnum;
    exp_q.delete();
    seen_q.delete();
    for (int w = 0; w < nw; w++) begin
      for (int f = 0; f < nf; f++) begin
        e.f    = fv[f];
        e.w    = wv[w];
        e.row  = fr[f] + wr[w];
        e.col  = fc[f] + wc[w];
        e.last = (f == nf - 1) && (w == nw - 1);
        exp_q.push_back(e);
      end
    end
    @(negedge clk);
    feature_valid_num = DW'(v.fnum);
    weight_valid_num  = DW'(v.wnum);
    start = 1'b1;
    mul_ready = 1'b1;
    @(negedge clk);
    start = 1'b0;
    chk({tag, "_busy_after_start"}, 32'(busy), 32'd1);
    chk({tag, "_valid_before_load"}, 32'(mul_valid), 32'd0);
    k = 0; stalled = 0; last_neg = -10; cyc = 0;
    got_done = 1'b0; first_seen = 1'b0; holding = 1'b0; pulsed = 1'b0;
    budget = nf * nw + v.stall_len + 10;
    while (cyc < budget && !got_done) begin
      @(negedge clk);
      if (start) start = 1'b0;
      cur = '{f: mul_feature, w: mul_weight, row: mul_row, col: mul_col, last: mul_last};
      if (holding) begin
        chk({tag, "_stall_hold"}, 32'({mul_valid, cur}), 32'({1'b1, held}));
        holding = 1'b0;
      end
      if (done) begin
        got_done = 1'b1;
        if (k > 0) chk({tag, "_done_latency"}, 32'(cyc - last_neg), 32'd2);
        chk({tag, "_busy_at_done"}, 32'(busy), 32'd0);
        chk({tag, "_pair_count"}, 32'(pair_count), 32'(v.exp_pairs));
      end else if (mul_valid) begin
        if (!first_seen) begin
          first_seen = 1'b1;
          chk({tag, "_first_latency"}, 32'(cyc), 32'd0);
        end
        if (k == v.stall_k && stalled < v.stall_len) begin
          mul_ready = 1'b0;
          stalled++;
          held = cur;
          holding = 1'b1;
        end else begin
          mul_ready = 1'b1;
          if (exp_q.size() == 0) begin
            chk({tag, "_extra_tuple"}, 32'd1, 32'd0);
          end else begin
            e = exp_q.pop_front();
            chk({tag, "_tuple"}, {cur.f, cur.w, cur.row, cur.col}, {e.f, e.w, e.row, e.col});
            chk({tag, "_last"}, 32'(cur.last), 32'(e.last));
          end
          seen_q.push_back(cur);
          k++;
          last_neg = cyc;
          if (v.start_k >= 0 && k == v.start_k && !pulsed) begin
            start = 1'b1;
            pulsed = 1'b1;
          end
        end
      end else begin
        mul_ready = 1'b1;
      end
      cyc++;
    end
    chk({tag, "_done_seen"}, 32'(got_done), 32'd1);
    chk({tag, "_transfers"}, 32'(k), 32'(v.exp_pairs));
    chk({tag, "_queue_empty"}, 32'(exp_q.size()), 32'd0);
    @(negedge clk);
    chk({tag, "_done_one_cycle"}, 32'(done), 32'd0);
    chk({tag, "_pair_count_held"}, 32'(pair_count), 32'(v.exp_pairs));
  endtask

  initial begin
    for (int i = 0; i < MF; i++) begin
      fv[i] = 8'(i * 37 + 11);
      fr[i] = 8'((i / 7) % 7);
      fc[i] = 8'(i % 7);
    end
    for (int i = 0; i < MW; i++) begin
      wv[i] = 8'(i * 13 + 5);
      wr[i] = 8'((i / 5) % 5);
      wc[i] = 8'(i % 5);
    end
    fv[0] = 8'h1a; fv[1] = 8'hfc; fv[11] = 8'hf4; fr[11] = 8'd1; fc[11] = 8'd2;
    wv[26] = 8'h00; wr[26] = 8'd0; wc[26] = 8'd2;
    for (int i = 0; i < MF; i++) begin
      feature_value[i*WL +: WL] = fv[i];
      feature_rows[i*CL +: CL]  = fr[i];
      feature_cols[i*CL +: CL]  = fc[i];
    end
    for (int i = 0; i < MW; i++) begin
      weight_value[i*WL +: WL] = wv[i];
      weight_rows[i*CL +: CL]  = wr[i];
      weight_cols[i*CL +: CL]  = wc[i];
    end

    //            fnum wnum stall_k stall_len start_k pairs
    tbl[0] = '{12, 27, -1, 0, -1, 324};
    tbl[1] = '{ 2,  3,  2, 3, -1,   6};
    tbl[2] = '{ 0,  5, -1, 0, -1,   0};
    tbl[3] = '{60,  1, -1, 0, -1,  52};
    tbl[4] = '{ 4,  0, -1, 0, -1,   0};
    tbl[5] = '{ 3,  2, -1, 0,  2,   6};
    tbl[6] = '{ 1,  1,  0, 2, -1,   1};
    tbl[7] = '{52, 28,  5, 1, -1, 1456};

    rst = 1'b0; start = 1'b0; clear = 1'b0; mul_ready = 1'b1;
    feature_valid_num = '0; weight_valid_num = '0;
    repeat (3) @(negedge clk);
    chk("reset_valid", 32'(mul_valid), 32'd0);
    chk("reset_busy", 32'(busy), 32'd0);
    chk("reset_done", 32'(done), 32'd0);
    chk("reset_pair_count", 32'(pair_count), 32'd0);
    rst = 1'b1;

    for (int t = 0; t < 8; t++) begin
      run_job(tbl[t], $sformatf("vec%0d", t));
      if (t == 0) begin
        chk("full_seen_count", 32'(seen_q.size()), 32'd324);
        if (seen_q.size() == 324) begin
          chk("full_tuple0", {seen_q[0].f, seen_q[0].w, seen_q[0].row, seen_q[0].col}, 32'h1a050000);
          chk("full_tuple1", {seen_q[1].f, seen_q[1].w, seen_q[1].row, seen_q[1].col}, 32'hfc050001);
          chk("full_tuple_last", {seen_q[323].f, seen_q[323].w, seen_q[323].row, seen_q[323].col}, 32'hf4000104);
          chk("full_last_flag", 32'(seen_q[323].last), 32'd1);
        end
      end
      if (t == 3 && seen_q.size() > 0) begin
        chk("clamp_last_feature", 32'(seen_q[seen_q.size()-1].f), 32'(fv[51]));
      end
    end

    // clear on the same edge as the final transfer
    @(negedge clk);
    feature_valid_num = 16'd2; weight_valid_num = 16'd1; start = 1'b1; mul_ready = 1'b1;
    @(negedge clk);
    start = 1'b0;
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      if (mul_valid && mul_last) break;
    end
    chk("clear_reached_last", 32'(mul_valid && mul_last), 32'd1);
    clear = 1'b1;
    @(negedge clk);
    clear = 1'b0;
    chk("clear_valid", 32'(mul_valid), 32'd0);
    chk("clear_busy", 32'(busy), 32'd0);
    chk("clear_done", 32'(done), 32'd0);
    @(negedge clk);
    chk("clear_no_done", 32'(done), 32'd0);
    run_job('{2, 1, -1, 0, -1, 2}, "after_clear");

    // asynchronous reset mid-job
    @(negedge clk);
    feature_valid_num = 16'd12; weight_valid_num = 16'd27; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    repeat (5) @(negedge clk);
    chk("pre_reset_valid", 32'(mul_valid), 32'd1);
    #2 rst = 1'b0;
    #1;
    chk("async_reset_valid", 32'(mul_valid), 32'd0);
    chk("async_reset_busy", 32'(busy), 32'd0);
    chk("async_reset_pair_count", 32'(pair_count), 32'd0);
    chk("async_reset_tuple", {mul_feature, mul_weight, mul_row, mul_col}, 32'd0);
    chk("async_reset_last_done", 32'({mul_last, done}), 32'd0);
    @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    chk("post_reset_idle", 32'({mul_valid, busy}), 32'd0);
    run_job('{3, 3, 4, 2, -1, 9}, "after_reset");

    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
